// File: rtl/hazard_ctrl.sv
// Pipeline sequencer beside ID: advances, holds or flushes PC and IF/ID and injects ID/EX bubbles.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             id_bubble_o,
`ifdef HAZARD_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic [1:0]       state_o
);

    localparam int unsigned STALL_W    = 3;
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_USE_STALL - 1);

    if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 7 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl: illegal LOAD_USE_STALL or CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic               uses_rs1, uses_rs2, load_use;

    // Register-operand usage decoded from the ID opcode.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode_i)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((uses_rs1 && (ex_rd_i == id_rs1_i)) ||
                       (uses_rs2 && (ex_rd_i == id_rs2_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and same-cycle pipeline controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        id_bubble_o  = 1'b1;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (!load_use) begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = id_branch_taken_i;
                    id_bubble_o  = 1'b0;
                end
                if (!start_i) begin
                    state_d = IDLE;
                end else if (load_use && (LOAD_USE_STALL > 1)) begin
                    state_d = STALL;
                    cnt_d   = STALL_LOAD;
                end
            end
            STALL: begin
                cnt_d = cnt_q - STALL_W'(1);
                if (!start_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STALL_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign state_o = state_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic stall_inc, flush_inc;

    // Bubbles in IDLE are not hazard cycles and are not counted.
    assign stall_inc = id_bubble_o && ((state_q == RUN) || (state_q == STALL));
    assign flush_inc = ifid_flush_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_inc && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_inc && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle stall, 3-cycle stall with 4-bit counters)
// checked against a behavioural model; counters compared when HAZARD_CTRL_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, ex_rd = 5'd0;
    logic       memread = 1'b0, br = 1'b0;

    logic       pc_a, ifid_a, flush_a, bub_a, pc_b, ifid_b, flush_b, bub_b;
    logic [1:0] state_a, state_b;
    logic [69:0] act [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;
`endif

    hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(32)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_opcode_i(opcode),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_memread_i(memread), .ex_rd_i(ex_rd),
        .id_branch_taken_i(br), .pc_write_o(pc_a), .ifid_write_o(ifid_a),
        .ifid_flush_o(flush_a), .id_bubble_o(bub_a),
`ifdef HAZARD_CTRL_PERF_CNT_EN
        .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a),
`endif
        .state_o(state_a));

    hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_opcode_i(opcode),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_memread_i(memread), .ex_rd_i(ex_rd),
        .id_branch_taken_i(br), .pc_write_o(pc_b), .ifid_write_o(ifid_b),
        .ifid_flush_o(flush_b), .id_bubble_o(bub_b),
`ifdef HAZARD_CTRL_PERF_CNT_EN
        .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b),
`endif
        .state_o(state_b));

    always_comb begin
`ifdef HAZARD_CTRL_PERF_CNT_EN
        act[0] = {state_a, pc_a, ifid_a, flush_a, bub_a, scnt_a, fcnt_a};
        act[1] = {state_b, pc_b, ifid_b, flush_b, bub_b, 28'd0, scnt_b, 28'd0, fcnt_b};
`else
        act[0] = {state_a, pc_a, ifid_a, flush_a, bub_a, 64'd0};
        act[1] = {state_b, pc_b, ifid_b, flush_b, bub_b, 64'd0};
`endif
    end

    // Behavioural model: running flag, stall cycles still owed, saturating counters.
    int          n_stall [2] = '{1, 3};
    longint      cnt_max [2] = '{64'hFFFF_FFFF, 64'd15};
    bit          m_run   [2] = '{0, 0};
    int          m_left  [2] = '{0, 0};
    longint      m_stall [2] = '{0, 0};
    longint      m_flush [2] = '{0, 0};

    function automatic bit hazard();
        bit r1, r2;
        r1 = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        r2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
        return memread && ex_rd != 0 && ((r1 && ex_rd == rs1) || (r2 && ex_rd == rs2));
    endfunction

    // {state, pc_write, ifid_write, ifid_flush, id_bubble}
    function automatic logic [5:0] outs(int i);
        if (!m_run[i])     return 6'b00_0001;
        if (m_left[i] > 0) return 6'b10_0001;
        if (hazard())      return 6'b01_0001;
        if (br)            return 6'b01_1110;
        return 6'b01_1100;
    endfunction

    function automatic logic [69:0] expv(int i);
`ifdef HAZARD_CTRL_PERF_CNT_EN
        return {outs(i), 32'(m_stall[i]), 32'(m_flush[i])};
`else
        return {outs(i), 64'd0};
`endif
    endfunction

    task automatic apply(input bit r, input bit s, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b, input bit mr, input logic [4:0] rd, input bit t);
        rst = r; start = s; opcode = op; rs1 = a; rs2 = b; memread = mr; ex_rd = rd; br = t;
        #1;
    endtask

    task automatic tick();
        logic [5:0] o;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            o = outs(i);
            if (rst) begin
                m_run[i] = 0; m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (m_run[i] && o[0] && m_stall[i] < cnt_max[i]) m_stall[i]++;
                if (o[1] && m_flush[i] < cnt_max[i]) m_flush[i]++;
                if (!m_run[i])          m_run[i] = start;
                else if (!start)        begin m_run[i] = 0; m_left[i] = 0; end
                else if (m_left[i] > 0) m_left[i]--;
                else if (o[0])          m_left[i] = n_stall[i] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1, 0, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick(); tick();
        if (act[0] !== expv(0) || act[1] !== expv(1)) begin
            errors++; $display("FAIL reset a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        if ({state_a, pc_a, ifid_a, flush_a, bub_a} !== 6'b00_0001) begin
            errors++; $display("FAIL reset_const got %b want 000001", {state_a, pc_a, ifid_a, flush_a, bub_a});
        end
        checks++;
        apply(0, 1, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
    endtask

    task automatic test_load_use();
        apply(0, 1, 7'b0110011, 5'd5, 5'd7, 1, 5'd5, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1)) begin
            errors++; $display("FAIL load_use a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        if ({pc_a, ifid_a, flush_a, bub_a} !== 4'b0001) begin
            errors++; $display("FAIL load_use_const got %b want 0001", {pc_a, ifid_a, flush_a, bub_a});
        end
        checks++;
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 7'b0110011, 5'd6, 5'd7, 0, 5'd0, 0);
            if (act[0] !== expv(0) || act[1] !== expv(1)) begin
                errors++; $display("FAIL load_use_after%0d a=%h exp %h b=%h exp %h", k, act[0], expv(0), act[1], expv(1));
            end
            checks++;
            tick();
        end
        if (pc_a !== 1'b1 || state_a !== 2'b01) begin
            errors++; $display("FAIL load_use_adv pc=%b state=%b want 1/01", pc_a, state_a);
        end
        checks++;
`ifdef HAZARD_CTRL_PERF_CNT_EN
        if (scnt_a !== 32'd1) begin
            errors++; $display("FAIL stall_cnt got %0d want 1", scnt_a);
        end
        checks++;
`endif
    endtask

    task automatic test_branch_in_stall();
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 7'b1100011, 5'd0, 5'd5, k == 0, 5'd5, 1);
            if (act[0] !== expv(0) || act[1] !== expv(1)) begin
                errors++; $display("FAIL branch_stall%0d a=%h exp %h b=%h exp %h", k, act[0], expv(0), act[1], expv(1));
            end
            checks++;
            if (state_b !== want[k] || flush_b !== (k == 3)) begin
                errors++; $display("FAIL branch_stall_state%0d got %b/%b want %b/%b", k, state_b, flush_b, want[k], k == 3);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_flush();
        apply(0, 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd1, 1);
        if (act[0] !== expv(0) || act[1] !== expv(1)) begin
            errors++; $display("FAIL flush a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
        apply(0, 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd1, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1) || flush_a !== 1'b0) begin
            errors++; $display("FAIL flush_end a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
    endtask

    task automatic test_no_stall();
        apply(0, 1, 7'b0000011, 5'd0, 5'd0, 1, 5'd0, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1) || bub_a !== 1'b0 || bub_b !== 1'b0) begin
            errors++; $display("FAIL x0_no_stall a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
        apply(0, 1, 7'b0010011, 5'd1, 5'd5, 1, 5'd5, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1) || bub_a !== 1'b0 || bub_b !== 1'b0) begin
            errors++; $display("FAIL imm_no_stall a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
    endtask

    task automatic test_abort_stall();
        apply(0, 1, 7'b0100011, 5'd9, 5'd3, 1, 5'd3, 0);
        tick();
        apply(0, 0, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1) || state_b !== 2'b10) begin
            errors++; $display("FAIL drop_in_stall a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
        if (act[0] !== expv(0) || act[1] !== expv(1) || state_b !== 2'b00) begin
            errors++; $display("FAIL drop_idle a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        apply(0, 1, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        apply(0, 1, 7'b0100011, 5'd9, 5'd3, 1, 5'd3, 0);
        tick();
        apply(1, 1, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        apply(0, 1, 7'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        if (act[0] !== expv(0) || act[1] !== expv(1) || state_b !== 2'b00) begin
            errors++; $display("FAIL rst_in_stall a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
        if (act[0] !== expv(0) || act[1] !== expv(1) || state_b !== 2'b01) begin
            errors++; $display("FAIL rst_cnt_cleared a=%h exp %h b=%h exp %h", act[0], expv(0), act[1], expv(1));
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b0110111, 7'b1101111, 7'b0000000};
        for (int k = 0; k < 3000; k++) begin
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
                  ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom));
            if (act[0] !== expv(0) || act[1] !== expv(1)) begin
                errors++; $display("FAIL random%0d a=%h exp %h b=%h exp %h", k, act[0], expv(0), act[1], expv(1));
            end
            checks++;
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_in_stall();
        test_flush();
        test_no_stall();
        test_abort_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
